// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - central shared-memory bus arbiter
// Priority write-backs beat normal requests, round-robin within each class, owner keeps the bus while holding.
module bus_arbiter #(
  parameter int NUM_DEV   = 4,
  parameter int ID_W      = 2,
  parameter int GRANT_TMO = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DEV-1:0] req,
  input  logic [NUM_DEV-1:0] req_type,
  input  logic [NUM_DEV-1:0] hold,
  output logic [NUM_DEV-1:0] grant,
  output logic               active,
  output logic [ID_W-1:0]    owner,
  output logic               tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t               state_q;
  logic [NUM_DEV-1:0]   grant_q;
  logic                 active_q;
  logic [ID_W-1:0]      owner_q;
  logic                 tmo_err_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [7:0]           tmo_cnt_q;

  logic [NUM_DEV-1:0]   cand;
  logic [ID_W:0]        scan_sum;
  logic [ID_W-1:0]      scan_idx;
  logic                 win_vld;
  logic [ID_W-1:0]      win_idx;
  logic                 rel;
  logic                 rel_tmo;
  logic [ID_W-1:0]      rr_ptr_d;

  // Priority class replaces the normal set entirely when any write-back is pending.
  always_comb begin
    cand     = (|(req & req_type)) ? (req & req_type) : req;
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (scan_sum >= (ID_W+1)'(NUM_DEV)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_DEV);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!win_vld && cand[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    rel     = 1'b0;
    rel_tmo = 1'b0;
    case (state_q)
      S_GRANT: begin
        if (!hold[owner_q]) begin
          if (!req[owner_q]) begin
            rel = 1'b1;
          end else if (tmo_cnt_q == 8'(GRANT_TMO - 1)) begin
            rel     = 1'b1;
            rel_tmo = 1'b1;
          end
        end
      end
      S_BUSY:  rel = !hold[owner_q];
      default: rel = 1'b0;
    endcase
    rr_ptr_d = (owner_q == ID_W'(NUM_DEV - 1)) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      active_q  <= 1'b0;
      owner_q   <= '0;
      tmo_err_q <= 1'b0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
    end else begin
      tmo_err_q <= 1'b0;
      if (rel) begin
        state_q   <= S_IDLE;
        grant_q   <= '0;
        active_q  <= 1'b0;
        owner_q   <= '0;
        tmo_err_q <= rel_tmo;
        rr_ptr_q  <= rr_ptr_d;
        tmo_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (win_vld) begin
              state_q   <= S_GRANT;
              grant_q   <= NUM_DEV'(1) << win_idx;
              active_q  <= 1'b1;
              owner_q   <= win_idx;
              tmo_cnt_q <= '0;
            end
          end
          S_GRANT: begin
            if (hold[owner_q]) begin
              state_q <= S_BUSY;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
          end
          S_BUSY: begin
            state_q <= S_BUSY;
          end
          default: begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            active_q <= 1'b0;
            owner_q  <= '0;
          end
        endcase
      end
    end
  end

  assign grant   = grant_q;
  assign active  = active_q;
  assign owner   = owner_q;
  assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_type;
  logic [3:0] hold;
  logic [3:0] grant;
  logic       active;
  logic [1:0] owner;
  logic       tmo_err;

  int tests = 0;
  int fails = 0;

  bus_arbiter #(.NUM_DEV(4), .ID_W(2), .GRANT_TMO(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_type (req_type),
    .hold     (hold),
    .grant    (grant),
    .active   (active),
    .owner    (owner),
    .tmo_err  (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every edge: grant one-hot or zero, owner matches the set grant bit.
  task automatic tick();
    logic [1:0] exp_own;
    @(posedge clk);
    #1;
    exp_own = 2'd0;
    for (int i = 0; i < 4; i++) if (grant[i]) exp_own = 2'(i);
    check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
    check("owner_match", 32'(owner), 32'(exp_own));
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic a,
                           input logic [1:0] o, input logic t);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_active"}, 32'(active), 32'(a));
    check({tag, "_owner"}, 32'(owner), 32'(o));
    check({tag, "_tmo"}, 32'(tmo_err), 32'(t));
  endtask

  initial begin
    logic [3:0] rr_order [5];
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // T1 reset dominates requests and holds
    rst = 1'b1; req = 4'b1111; req_type = 4'b0000; hold = 4'b1111;
    tick();
    check_out("t1_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    check("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    tick();
    rst = 1'b0; req = 4'b0000; hold = 4'b0000;
    tick();
    check_out("t1_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

    // T2 single requester, hold rises two edges after grant, held 3 cycles
    req = 4'b0100;
    tick();
    check_out("t2_grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    tick();
    check_out("t2_wait", 4'b0100, 1'b1, 2'd2, 1'b0);
    hold = 4'b0100;
    tick();
    check_out("t2_busy1", 4'b0100, 1'b1, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t2_busy2", 4'b0100, 1'b1, 2'd2, 1'b0);
    tick();
    check_out("t2_busy3", 4'b0100, 1'b1, 2'd2, 1'b0);
    hold = 4'b0000;
    tick();
    check_out("t2_release", 4'b0000, 1'b0, 2'd0, 1'b0);
    check("t2_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);

    // T3 round-robin from reset with all devices requesting
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_grant", 32'(grant), 32'(rr_order[k]));
      hold = rr_order[k];
      tick();
      check("t3_held1", 32'(grant), 32'(rr_order[k]));
      tick();
      check("t3_held2", 32'(grant), 32'(rr_order[k]));
      hold = 4'b0000;
      tick();
      check("t3_idle_gap", 32'(grant), 32'd0);
      check("t3_idle_active", 32'(active), 32'd0);
    end

    // T4 priority wins, but never preempts a busy owner
    req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b0011; req_type = 4'b0010;
    tick();
    check_out("t4_prio_first", 4'b0010, 1'b1, 2'd1, 1'b0);
    hold = 4'b0010; req = 4'b0001; req_type = 4'b0000;
    tick();
    hold = 4'b0000;
    tick();
    check_out("t4_rel1", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check_out("t4_dev0", 4'b0001, 1'b1, 2'd0, 1'b0);
    hold = 4'b0001;
    tick();
    req = 4'b1001; req_type = 4'b1000;
    tick();
    check_out("t4_no_preempt1", 4'b0001, 1'b1, 2'd0, 1'b0);
    tick();
    check_out("t4_no_preempt2", 4'b0001, 1'b1, 2'd0, 1'b0);
    hold = 4'b0000;
    tick();
    check_out("t4_rel2", 4'b0000, 1'b0, 2'd0, 1'b0);
    check("t4_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);
    tick();
    check_out("t4_dev3", 4'b1000, 1'b1, 2'd3, 1'b0);
    req = 4'b0000; req_type = 4'b0000;
    tick();
    check_out("t4_withdrawn", 4'b0000, 1'b0, 2'd0, 1'b0);

    // T5 grant timeout with hold never rising
    req = 4'b0001;
    tick();
    check_out("t5_grant", 4'b0001, 1'b1, 2'd0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("t5_grant_hold", 32'(grant), 32'h1);
      check("t5_no_tmo", 32'(tmo_err), 32'd0);
    end
    tick();
    check_out("t5_timeout", 4'b0000, 1'b0, 2'd0, 1'b1);
    check("t5_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);
    req = 4'b0000;
    tick();
    check_out("t5_pulse_end", 4'b0000, 1'b0, 2'd0, 1'b0);

    // T6 reset while dev2 is busy, then non-owner hold is ignored
    req = 4'b0100;
    tick();
    check_out("t6_grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    hold = 4'b0100;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_out("t6_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    check("t6_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    rst = 1'b0; req = 4'b0101;
    tick();
    check_out("t6_dev0", 4'b0001, 1'b1, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
